// File: rtl/soc_sram_pkg.sv
// Shared defaults, port indices and read-tag type for the SoC SRAM arbiter slice.
package soc_sram_pkg;

   localparam int unsigned SRAM_ADDR_W = 20;
   localparam int unsigned SRAM_DATA_W = 32;
   localparam int unsigned SRAM_STRB_W = SRAM_DATA_W / 8;
   localparam int unsigned SRAM_RD_LAT = 4;

   typedef enum logic {
      SRAM_PORT_IF = 1'b0,
      SRAM_PORT_LS = 1'b1
   } sram_port_e;

   typedef struct packed {
      logic       valid;
      sram_port_e owner;
   } sram_rd_tag_t;

endpackage

// File: rtl/soc_sram_rr_pick.sv
// Two-way round-robin picker: on a conflict the port granted least recently wins.
module soc_sram_rr_pick
   import soc_sram_pkg::*;
(
   input  logic       clk,
   input  logic       resetn,
   input  logic [1:0] req,
   input  logic       readya,
   output logic [1:0] gnt
);

   sram_port_e last_q;
   sram_port_e last_d;

   always_comb begin
      gnt = '0;
      if (readya) begin
         unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_q == SRAM_PORT_LS) ? 2'b01 : 2'b10;
            default: gnt = '0;
         endcase
      end
   end

   always_comb begin
      last_d = last_q;
      if (gnt[SRAM_PORT_LS]) begin
         last_d = SRAM_PORT_LS;
      end else if (gnt[SRAM_PORT_IF]) begin
         last_d = SRAM_PORT_IF;
      end
   end

   // Reset marks port 1 as most recent so port 0 takes the first conflict.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         last_q <= SRAM_PORT_LS;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/soc_sram_arbiter.sv
// Two-port arbiter in front of the async-SRAM controller, routing read data back to its issuer.
// Build option SOC_SRAM_ARB_FIXED_PRIO_EN: fixed priority (port 1 wins) instead of round-robin.
module soc_sram_arbiter
   import soc_sram_pkg::*;
#(
   parameter int unsigned ADDR_W = SRAM_ADDR_W,
   parameter int unsigned DATA_W = SRAM_DATA_W,
   parameter int unsigned STRB_W = SRAM_STRB_W,
   parameter int unsigned RD_LAT = SRAM_RD_LAT
)(
   input  logic              clk,
   input  logic              resetn,
   input  logic              m0_req,
   input  logic [STRB_W-1:0] m0_wstrb,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic [STRB_W-1:0] m1_wstrb,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              sram_ena,
   output logic [STRB_W-1:0] sram_wea,
   output logic [ADDR_W-1:0] sram_addra,
   output logic [DATA_W-1:0] sram_dina,
   input  logic [DATA_W-1:0] sram_douta,
   input  logic              sram_readya
);

   logic                      ready_ok;
   logic [1:0]                req;
   logic [1:0]                gnt;
   logic                      acc_rd;
   sram_rd_tag_t              rd_push;
   sram_rd_tag_t              rd_head;
   sram_rd_tag_t [RD_LAT-1:0] rd_pipe_q;
   sram_rd_tag_t [RD_LAT-1:0] rd_pipe_d;

   assign ready_ok = sram_readya & resetn;
   assign req      = {m1_req, m0_req};

`ifdef SOC_SRAM_ARB_FIXED_PRIO_EN
   assign gnt[SRAM_PORT_LS] = ready_ok & req[SRAM_PORT_LS];
   assign gnt[SRAM_PORT_IF] = ready_ok & req[SRAM_PORT_IF] & ~req[SRAM_PORT_LS];
`else
   soc_sram_rr_pick u_rr_pick (
      .clk    (clk),
      .resetn (resetn),
      .req    (req),
      .readya (ready_ok),
      .gnt    (gnt)
   );
`endif

   assign m0_gnt   = gnt[SRAM_PORT_IF];
   assign m1_gnt   = gnt[SRAM_PORT_LS];
   assign sram_ena = ready_ok & (m0_req | m1_req);

   always_comb begin
      sram_wea   = '0;
      sram_addra = '0;
      sram_dina  = '0;
      if (gnt[SRAM_PORT_LS]) begin
         sram_wea   = m1_wstrb;
         sram_addra = m1_addr;
         sram_dina  = m1_wdata;
      end else if (gnt[SRAM_PORT_IF]) begin
         sram_wea   = m0_wstrb;
         sram_addra = m0_addr;
         sram_dina  = m0_wdata;
      end
   end

   // Every cycle shifts one tag in; idle cycles and writes insert valid=0 bubbles.
   assign acc_rd        = (|gnt) & (sram_wea == '0);
   assign rd_push.valid = acc_rd;
   assign rd_push.owner = gnt[SRAM_PORT_LS] ? SRAM_PORT_LS : SRAM_PORT_IF;

   always_comb begin
      rd_pipe_d = {rd_pipe_q[RD_LAT-2:0], rd_push};
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         rd_pipe_q <= '0;
      end else begin
         rd_pipe_q <= rd_pipe_d;
      end
   end

   assign rd_head   = rd_pipe_q[RD_LAT-1];
   assign m0_rvalid = resetn & rd_head.valid & (rd_head.owner == SRAM_PORT_IF);
   assign m1_rvalid = resetn & rd_head.valid & (rd_head.owner == SRAM_PORT_LS);
   assign m0_rdata  = m0_rvalid ? sram_douta : '0;
   assign m1_rdata  = m1_rvalid ? sram_douta : '0;

endmodule

// File: tb/tb_soc_sram_arbiter.sv
// Bench for soc_sram_arbiter: directed scenarios plus random traffic against a queue-based reference model.
module tb_soc_sram_arbiter;
   import soc_sram_pkg::*;

   localparam int unsigned ADDR_W = 20;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = 4;
   localparam int unsigned RD_LAT = 4;

   logic              clk = 1'b0;
   logic              resetn = 1'b0;
   logic              m0_req = 1'b0, m1_req = 1'b0;
   logic [STRB_W-1:0] m0_wstrb = '0, m1_wstrb = '0;
   logic [ADDR_W-1:0] m0_addr = '0, m1_addr = '0;
   logic [DATA_W-1:0] m0_wdata = '0, m1_wdata = '0;
   logic              m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
   logic [DATA_W-1:0] m0_rdata, m1_rdata;
   logic              sram_ena;
   logic [STRB_W-1:0] sram_wea;
   logic [ADDR_W-1:0] sram_addra;
   logic [DATA_W-1:0] sram_dina;
   logic [DATA_W-1:0] sram_douta;
   logic              sram_readya;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int busy_cnt = 0;
   bit force_busy = 1'b0;

   soc_sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .resetn(resetn),
      .m0_req(m0_req), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .sram_ena(sram_ena), .sram_wea(sram_wea), .sram_addra(sram_addra), .sram_dina(sram_dina),
      .sram_douta(sram_douta), .sram_readya(sram_readya)
   );

   always #5 clk = ~clk;

   // ---------------- SRAM controller model ----------------
   logic [31:0] mem [int];

   function automatic logic [31:0] rd_mem(input logic [19:0] a);
      if (mem.exists(int'(a))) return mem[int'(a)];
      return {12'hA5C, a};
   endfunction

   function automatic void mem_write(input logic [19:0] a, input logic [3:0] be, input logic [31:0] d);
      logic [31:0] w;
      w = rd_mem(a);
      for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
      mem[int'(a)] = w;
   endfunction

   typedef struct { int due; logic [31:0] data; } env_rd_t;
   env_rd_t env_q[$];

   assign sram_readya = (busy_cnt == 0) && !force_busy;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
      if (sram_ena) begin
         busy_cnt <= 2;
         if (sram_wea == '0) env_q.push_back('{due: cyc + int'(RD_LAT), data: rd_mem(sram_addra)});
         else mem_write(sram_addra, sram_wea, sram_dina);
      end
      if (env_q.size() > 0 && env_q[0].due == cyc + 1) begin
         sram_douta <= env_q[0].data;
         void'(env_q.pop_front());
      end else begin
         sram_douta <= $urandom;
      end
   end

   // ---------------- Reference model ----------------
   typedef struct { int due; bit port; logic [31:0] data; } exp_rd_t;
   exp_rd_t exp_q[$];
   bit   last_ls = 1'b1;
   logic exp_g0, exp_g1;

   always_comb begin
      exp_g0 = 1'b0;
      exp_g1 = 1'b0;
      if (resetn && sram_readya) begin
         if (m0_req && m1_req) begin
`ifdef SOC_SRAM_ARB_FIXED_PRIO_EN
            exp_g1 = 1'b1;
`else
            if (last_ls) exp_g0 = 1'b1;
            else         exp_g1 = 1'b1;
`endif
         end else begin
            exp_g0 = m0_req;
            exp_g1 = m1_req;
         end
      end
   end

   always @(posedge clk) begin
      if (!resetn) begin
         exp_q.delete();
         last_ls <= 1'b1;
      end else begin
         while (exp_q.size() > 0 && exp_q[0].due <= cyc) void'(exp_q.pop_front());
         if (exp_g0 || exp_g1) begin
            last_ls <= exp_g1;
            if ((exp_g1 ? m1_wstrb : m0_wstrb) == '0)
               exp_q.push_back('{due: cyc + int'(RD_LAT), port: exp_g1,
                                 data: rd_mem(exp_g1 ? m1_addr : m0_addr)});
         end
      end
   end

   function automatic bit exp_rv(input bit port);
      return resetn && exp_q.size() > 0 && exp_q[0].due == cyc && exp_q[0].port == port;
   endfunction

   task automatic idle(input int n);
      m0_req = 1'b0;
      m1_req = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---------------- Scenarios ----------------
   task automatic test_reset();
      resetn = 1'b0;
      m0_req = 1'b1; m0_wstrb = '0;    m0_addr = 20'h00123;
      m1_req = 1'b1; m1_wstrb = 4'hF; m1_addr = 20'h00456; m1_wdata = 32'h55AA55AA;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({m1_gnt, m0_gnt, m1_rvalid, m0_rvalid} !== 4'b0000) begin
         n_bad++;
         $display("FAIL reset_gnt_rvalid: got %b want 0000", {m1_gnt, m0_gnt, m1_rvalid, m0_rvalid});
      end
      n_cmp++;
      if (sram_ena !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_ena: got %b want 0", sram_ena);
      end
      n_cmp++;
      if ({sram_wea, sram_addra, sram_dina} !== '0) begin
         n_bad++;
         $display("FAIL reset_sram_bus: got wea=%h addr=%h din=%h want 0", sram_wea, sram_addra, sram_dina);
      end
      @(posedge clk); #1;
      resetn = 1'b1;
      m0_req = 1'b0;
      m1_req = 1'b0;
   endtask

   task automatic test_single_read();
      mem[32'h10] = 32'hDEADBEEF;
      m0_req = 1'b1; m0_wstrb = '0; m0_addr = 20'h00010;
      @(negedge clk);
      n_cmp++;
      if ({m1_gnt, m0_gnt} !== 2'b01) begin
         n_bad++;
         $display("FAIL single_gnt: got %b want 01", {m1_gnt, m0_gnt});
      end
      n_cmp++;
      if ({sram_ena, sram_wea, sram_addra} !== {1'b1, 4'h0, 20'h00010}) begin
         n_bad++;
         $display("FAIL single_ctrl: got ena=%b wea=%h addr=%h want 1/0/00010", sram_ena, sram_wea, sram_addra);
      end
      @(posedge clk); #1;
      m0_req = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         n_cmp++;
         if ({m1_rvalid, m0_rvalid} !== ((k == 4) ? 2'b01 : 2'b00)) begin
            n_bad++;
            $display("FAIL single_rvalid t+%0d: got %b want %b", k, {m1_rvalid, m0_rvalid}, (k == 4) ? 2'b01 : 2'b00);
         end
         if (k == 4) begin
            n_cmp++;
            if (m0_rdata !== 32'hDEADBEEF) begin
               n_bad++;
               $display("FAIL single_rdata: got %h want deadbeef", m0_rdata);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_conflict_rr();
      resetn = 1'b0;
      m0_req = 1'b0;
      m1_req = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      m0_req = 1'b1; m0_wstrb = '0; m0_addr = 20'h00100;
      m1_req = 1'b1; m1_wstrb = '0; m1_addr = 20'h00200;
      for (int k = 0; k < 14; k++) begin
         logic [1:0]  eg, er;
         logic [19:0] ea;
         int          g;
         @(negedge clk);
         eg = 2'b00;
`ifdef SOC_SRAM_ARB_FIXED_PRIO_EN
         if (k % 3 == 0) eg = 2'b10;
`else
         if (k % 3 == 0) eg = ((k / 3) % 2 == 0) ? 2'b01 : 2'b10;
`endif
         n_cmp++;
         if ({m1_gnt, m0_gnt} !== eg) begin
            n_bad++;
            $display("FAIL conflict_gnt k=%0d: got %b want %b", k, {m1_gnt, m0_gnt}, eg);
         end
         er = 2'b00;
         ea = '0;
         if (k >= 4 && (k - 4) % 3 == 0) begin
            g = (k - 4) / 3;
`ifdef SOC_SRAM_ARB_FIXED_PRIO_EN
            er = 2'b10;
            ea = 20'h00200 + 20'(g);
`else
            er = (g % 2 == 0) ? 2'b01 : 2'b10;
            ea = (g % 2 == 0) ? 20'h00100 + 20'(g / 2) : 20'h00200 + 20'(g / 2);
`endif
         end
         n_cmp++;
         if ({m1_rvalid, m0_rvalid} !== er) begin
            n_bad++;
            $display("FAIL conflict_rvalid k=%0d: got %b want %b", k, {m1_rvalid, m0_rvalid}, er);
         end
         if (er != 2'b00) begin
            n_cmp++;
            if ((er[1] ? m1_rdata : m0_rdata) !== rd_mem(ea)) begin
               n_bad++;
               $display("FAIL conflict_rdata k=%0d: got %h want %h", k, er[1] ? m1_rdata : m0_rdata, rd_mem(ea));
            end
         end
         @(posedge clk); #1;
         if (eg[0]) m0_addr = m0_addr + 20'd1;
         if (eg[1]) m1_addr = m1_addr + 20'd1;
      end
   endtask

   task automatic test_write_read();
      mem[32'h20] = 32'hCAFEBABE;
      m1_req = 1'b1; m1_wstrb = 4'b0011; m1_addr = 20'h00020; m1_wdata = 32'h12345678;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         n_cmp++;
         if ({m1_gnt, m0_gnt} !== ((k == 0 || k == 3) ? 2'b10 : 2'b00)) begin
            n_bad++;
            $display("FAIL wr_rd_gnt k=%0d: got %b", k, {m1_gnt, m0_gnt});
         end
         if (k == 0) begin
            n_cmp++;
            if ({sram_wea, sram_addra, sram_dina} !== {4'b0011, 20'h00020, 32'h12345678}) begin
               n_bad++;
               $display("FAIL wr_bus: got wea=%b addr=%h din=%h want 0011/00020/12345678", sram_wea, sram_addra, sram_dina);
            end
         end
         n_cmp++;
         if ({m1_rvalid, m0_rvalid} !== ((k == 7) ? 2'b10 : 2'b00)) begin
            n_bad++;
            $display("FAIL wr_rd_rvalid k=%0d: got %b", k, {m1_rvalid, m0_rvalid});
         end
         if (k == 7) begin
            n_cmp++;
            if (m1_rdata !== 32'hCAFE5678) begin
               n_bad++;
               $display("FAIL wr_rd_rdata: got %h want cafe5678", m1_rdata);
            end
         end
         @(posedge clk); #1;
         if (k == 0) m1_wstrb = '0;
         if (k == 3) m1_req = 1'b0;
      end
   endtask

   task automatic test_busy_hold();
      force_busy = 1'b1;
      m0_req = 1'b1; m0_wstrb = '0; m0_addr = 20'h00033;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_cmp++;
         if ({m0_gnt, sram_ena} !== 2'b00) begin
            n_bad++;
            $display("FAIL busy_hold k=%0d: got gnt=%b ena=%b want 0/0", k, m0_gnt, sram_ena);
         end
         @(posedge clk); #1;
      end
      force_busy = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({m0_gnt, sram_ena, sram_addra} !== {1'b1, 1'b1, 20'h00033}) begin
         n_bad++;
         $display("FAIL busy_release: got gnt=%b ena=%b addr=%h want 1/1/00033", m0_gnt, sram_ena, sram_addra);
      end
      @(posedge clk); #1;
      m0_req = 1'b0;
   endtask

   task automatic test_reset_mid_read();
      m0_req = 1'b1; m0_wstrb = '0; m0_addr = 20'h00044;
      @(negedge clk);
      n_cmp++;
      if (m0_gnt !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_mid_accept: got %b want 1", m0_gnt);
      end
      @(posedge clk); #1;
      m0_req = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b0;
      m0_req = 1'b1;
      m1_req = 1'b1; m1_wstrb = '0; m1_addr = 20'h00055;
      for (int k = 2; k <= 3; k++) begin
         @(negedge clk);
         n_cmp++;
         if ({m1_gnt, m0_gnt, m1_rvalid, m0_rvalid, sram_ena, sram_wea, sram_addra, sram_dina} !== '0) begin
            n_bad++;
            $display("FAIL rst_mid_outputs t+%0d: got gnt=%b rv=%b ena=%b addr=%h", k,
                     {m1_gnt, m0_gnt}, {m1_rvalid, m0_rvalid}, sram_ena, sram_addra);
         end
         @(posedge clk); #1;
      end
      resetn = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({m1_rvalid, m0_rvalid} !== 2'b00) begin
         n_bad++;
         $display("FAIL rst_mid_dropped: got rvalid=%b want 00", {m1_rvalid, m0_rvalid});
      end
      n_cmp++;
`ifdef SOC_SRAM_ARB_FIXED_PRIO_EN
      if ({m1_gnt, m0_gnt} !== 2'b10) begin
`else
      if ({m1_gnt, m0_gnt} !== 2'b01) begin
`endif
         n_bad++;
         $display("FAIL rst_mid_first_conflict: got %b", {m1_gnt, m0_gnt});
      end
      @(posedge clk); #1;
      m0_req = 1'b0;
      m1_req = 1'b0;
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         logic [1:0]  eg, er;
         logic [55:0] ebus;
         if (!m0_req && $urandom_range(0, 1) == 1) begin
            m0_req   = 1'b1;
            m0_addr  = 20'($urandom_range(0, 15));
            m0_wstrb = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
            m0_wdata = $urandom;
         end
         if (!m1_req && $urandom_range(0, 1) == 1) begin
            m1_req   = 1'b1;
            m1_addr  = 20'($urandom_range(0, 15));
            m1_wstrb = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
            m1_wdata = $urandom;
         end
         force_busy = ($urandom_range(0, 9) == 0);
         resetn     = ($urandom_range(0, 99) != 0);
         @(negedge clk);
         eg = {exp_g1, exp_g0};
         n_cmp++;
         if ({m1_gnt, m0_gnt} !== eg) begin
            n_bad++;
            $display("FAIL rand_gnt c=%0d: got %b want %b", c, {m1_gnt, m0_gnt}, eg);
         end
         n_cmp++;
         if (sram_ena !== (resetn & sram_readya & (m0_req | m1_req))) begin
            n_bad++;
            $display("FAIL rand_ena c=%0d: got %b", c, sram_ena);
         end
         ebus = eg[1] ? {m1_wstrb, m1_addr, m1_wdata} : eg[0] ? {m0_wstrb, m0_addr, m0_wdata} : 56'h0;
         n_cmp++;
         if ({sram_wea, sram_addra, sram_dina} !== ebus) begin
            n_bad++;
            $display("FAIL rand_bus c=%0d: got %h want %h", c, {sram_wea, sram_addra, sram_dina}, ebus);
         end
         er = {exp_rv(1'b1), exp_rv(1'b0)};
         n_cmp++;
         if ({m1_rvalid, m0_rvalid} !== er) begin
            n_bad++;
            $display("FAIL rand_rvalid c=%0d: got %b want %b", c, {m1_rvalid, m0_rvalid}, er);
         end
         if (er != 2'b00) begin
            n_cmp++;
            if ((er[1] ? m1_rdata : m0_rdata) !== exp_q[0].data) begin
               n_bad++;
               $display("FAIL rand_rdata c=%0d: got %h want %h", c, er[1] ? m1_rdata : m0_rdata, exp_q[0].data);
            end
         end
         @(posedge clk); #1;
         if (eg[0]) m0_req = 1'b0;
         if (eg[1]) m1_req = 1'b0;
      end
      force_busy = 1'b0;
      resetn = 1'b1;
   endtask

   initial begin
      #1;
      test_reset();
      idle(6);
      test_single_read();
      idle(6);
      test_conflict_rr();
      idle(8);
      test_write_read();
      idle(6);
      test_busy_hold();
      idle(8);
      test_reset_mid_read();
      idle(8);
      test_random();
      idle(8);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached before the scenarios completed");
      $fatal(1);
   end

endmodule
